// File: rtl/axi_dma_read_master.sv
// AXI4 read master for the DMA source side: splits a job into INCR bursts that never
// cross a 4KB page and streams R beats into the DMA FIFO. Optional: DMA_RD_PERF_CNT_EN.
module axi_dma_read_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_MAX_BURST_LEN    = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_start,
    input  logic [31:0]                   i_src_addr,
    input  logic [31:0]                   i_total_len,
    output logic                          o_read_done,
    output logic                          o_busy,
    output logic                          o_error,
    output logic                          o_fifo_wr_en,
    output logic [31:0]                   o_fifo_wdata,
    input  logic                          i_fifo_full,
`ifdef DMA_RD_PERF_CNT_EN
    output logic [31:0]                   o_busy_cycles,
    output logic [31:0]                   o_stall_cycles,
`endif
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    output logic [2:0]                    m_axi_arsize,
    output logic [1:0]                    m_axi_arburst,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rlast,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready
);
    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_NEXT, S_DONE} state_t;

    state_t                        state_q, state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] start_addr, burst_addr;
    logic [29:0]                   rem_words_q, rem_words_d, start_words, burst_words;
    logic [8:0]                    beats_q, beats_d, beat_cnt_q, beat_cnt_d;
    logic [8:0]                    next_beats, next_beats_m1;
    logic [7:0]                    arlen_q, arlen_d;
    logic                          arvalid_q, arvalid_d;
    logic                          read_done_q, read_done_d;
    logic                          busy_q, busy_d;
    logic                          error_q, error_d;
    logic                          start_acc, r_beat, last_beat;
    logic                          unused_bits;

    // Beats for the next burst: limited by max burst, words left, and words to the 4KB page end.
    function automatic logic [8:0] calc_beats(input logic [11:0] addr_lo, input logic [29:0] words);
        logic [12:0] page_bytes;
        logic [10:0] page_words;
        logic [8:0]  b;
        page_bytes = 13'h1000 - {1'b0, addr_lo};
        page_words = page_bytes[12:2];
        b = 9'(C_MAX_BURST_LEN);
        if (words < {21'd0, b}) b = words[8:0];
        if (page_words < {2'd0, b}) b = page_words[8:0];
        return b;
    endfunction

    assign unused_bits   = ^{i_src_addr[1:0], i_total_len[1:0]};
    assign start_addr    = {i_src_addr[C_M_AXI_ADDR_WIDTH-1:2], 2'b00};
    assign start_words   = i_total_len[31:2];
    assign start_acc     = (state_q == S_IDLE) && i_start;
    assign burst_addr    = (state_q == S_IDLE) ? start_addr : cur_addr_q;
    assign burst_words   = (state_q == S_IDLE) ? start_words : rem_words_q;
    assign next_beats    = calc_beats(burst_addr[11:0], burst_words);
    assign next_beats_m1 = next_beats - 9'd1;

    assign m_axi_rready  = (state_q == S_R) && !i_fifo_full;
    assign r_beat        = m_axi_rready && m_axi_rvalid;
    assign last_beat     = (beat_cnt_q == beats_q - 9'd1);
    assign o_fifo_wr_en  = r_beat;
    assign o_fifo_wdata  = r_beat ? m_axi_rdata[31:0] : 32'd0;

    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_arsize  = 3'b010;
    assign m_axi_arburst = 2'b01;
    assign o_read_done   = read_done_q;
    assign o_busy        = busy_q;
    assign o_error       = error_q;

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        rem_words_d = rem_words_q;
        beats_d     = beats_q;
        beat_cnt_d  = beat_cnt_q;
        araddr_d    = araddr_q;
        arlen_d     = arlen_q;
        arvalid_d   = arvalid_q;
        read_done_d = 1'b0;
        error_d     = error_q;
        // busy covers the done pulse, then drops the cycle after it
        busy_d      = busy_q && !read_done_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    busy_d      = 1'b1;
                    error_d     = 1'b0;
                    cur_addr_d  = start_addr;
                    rem_words_d = start_words;
                    if (start_words != 30'd0) begin
                        beats_d   = next_beats;
                        araddr_d  = start_addr;
                        arlen_d   = next_beats_m1[7:0];
                        arvalid_d = 1'b1;
                        state_d   = S_AR;
                    end else begin
                        state_d   = S_DONE;
                    end
                end
            end
            S_AR: begin
                if (m_axi_arready) begin
                    arvalid_d  = 1'b0;
                    beat_cnt_d = 9'd0;
                    state_d    = S_R;
                end
            end
            S_R: begin
                if (r_beat) begin
                    if (m_axi_rresp != 2'b00) error_d = 1'b1;
                    if (m_axi_rlast != last_beat) error_d = 1'b1;
                    // burst end is decided by our own count, not by rlast
                    if (last_beat) begin
                        cur_addr_d  = cur_addr_q + C_M_AXI_ADDR_WIDTH'({beats_q, 2'b00});
                        rem_words_d = rem_words_q - {21'd0, beats_q};
                        state_d     = S_NEXT;
                    end else begin
                        beat_cnt_d  = beat_cnt_q + 9'd1;
                    end
                end
            end
            S_NEXT: begin
                if (rem_words_q != 30'd0) begin
                    beats_d   = next_beats;
                    araddr_d  = cur_addr_q;
                    arlen_d   = next_beats_m1[7:0];
                    arvalid_d = 1'b1;
                    state_d   = S_AR;
                end else begin
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                read_done_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            rem_words_q <= '0;
            beats_q     <= '0;
            beat_cnt_q  <= '0;
            araddr_q    <= '0;
            arlen_q     <= '0;
            arvalid_q   <= 1'b0;
            read_done_q <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            rem_words_q <= rem_words_d;
            beats_q     <= beats_d;
            beat_cnt_q  <= beat_cnt_d;
            araddr_q    <= araddr_d;
            arlen_q     <= arlen_d;
            arvalid_q   <= arvalid_d;
            read_done_q <= read_done_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
        end
    end

`ifdef DMA_RD_PERF_CNT_EN
    logic [31:0] busy_cycles_q, busy_cycles_d, stall_cycles_q, stall_cycles_d;

    always_comb begin
        busy_cycles_d  = busy_cycles_q;
        stall_cycles_d = stall_cycles_q;
        if (start_acc) begin
            busy_cycles_d  = 32'd0;
            stall_cycles_d = 32'd0;
        end else begin
            if (busy_q && (busy_cycles_q != 32'hFFFF_FFFF))
                busy_cycles_d = busy_cycles_q + 32'd1;
            if ((state_q == S_R) && m_axi_rvalid && i_fifo_full && (stall_cycles_q != 32'hFFFF_FFFF))
                stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_cycles_q  <= 32'd0;
            stall_cycles_q <= 32'd0;
        end else begin
            busy_cycles_q  <= busy_cycles_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign o_busy_cycles  = busy_cycles_q;
    assign o_stall_cycles = stall_cycles_q;
`endif

endmodule
